// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants for the decode/writeback slice.
package y86_pkg;
    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;
    localparam logic [3:0] REG_RSP      = 4'h4;
    localparam logic [3:0] REG_NONE     = 4'hF;
    localparam logic [3:0] STAT_AOK     = 4'b1000;
    localparam logic [3:0] STAT_HLT     = 4'b0100;
    localparam logic [3:0] STAT_ADR     = 4'b0010;
    localparam logic [3:0] STAT_INS     = 4'b0001;
    localparam logic [3:0] BUBBLE_ICODE = ICODE_NOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
    localparam logic [3:0] BUBBLE_STAT  = STAT_AOK;
endpackage

// File: rtl/decode_writeback_if.sv
// decode_writeback_if: D-register inputs, forwarding sources, W write port and E-register outputs.
interface decode_writeback_if #(parameter int DATA_W = 64);
    logic [3:0]        D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [DATA_W-1:0] D_valC, D_valP;
    logic              E_bubble;
    logic [3:0]        e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [DATA_W-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]        d_srcA, d_srcB;
    logic [3:0]        E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [DATA_W-1:0] E_valC, E_valA, E_valB;
    modport master (
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, E_bubble,
               e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM, W_dstE, W_valE, W_dstM, W_valM,
        input  d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB
    );
    modport slave (
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, E_bubble,
               e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM, W_dstE, W_valE, W_dstM, W_valM,
        output d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/y86_regfile.sv
// y86_regfile: 15 x DATA_W registers, two async reads, two sync writes (port M overrides port E).
module y86_regfile import y86_pkg::*; #(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = 64'd1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        i_src_a,
    input  logic [3:0]        i_src_b,
    input  logic [3:0]        i_dst_e,
    input  logic [3:0]        i_dst_m,
    input  logic [DATA_W-1:0] i_val_e,
    input  logic [DATA_W-1:0] i_val_m,
    output logic [DATA_W-1:0] o_val_a,
    output logic [DATA_W-1:0] o_val_b
);
    logic [DATA_W-1:0] r_rf [15];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) r_rf[i] <= (4'(i) == REG_RSP) ? RSP_INIT : '0;
        end else begin
            if (i_dst_e != REG_NONE) r_rf[i_dst_e] <= i_val_e;
            if (i_dst_m != REG_NONE) r_rf[i_dst_m] <= i_val_m;
        end
    end
    assign o_val_a = (i_src_a == REG_NONE) ? '0 : r_rf[i_src_a];
    assign o_val_b = (i_src_b == REG_NONE) ? '0 : r_rf[i_src_b];
endmodule

// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 Decode stage + RF writeback port, registering the E pipeline register.
// DECODE_FWD_EN selects the full e/M/W forwarding chain; otherwise only a W write-first bypass.
module decode_writeback import y86_pkg::*; #(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = 64'd1000
) (
    input logic             clk,
    input logic             rst,
    decode_writeback_if.slave bus
);
    logic [3:0]        w_src_a, w_src_b, w_dst_e, w_dst_m;
    logic [DATA_W-1:0] w_rf_a, w_rf_b, w_fwd_a, w_fwd_b, w_val_a, w_val_b;
    logic [3:0]        r_stat, r_icode, r_ifun, r_dst_e, r_dst_m, r_src_a, r_src_b;
    logic [DATA_W-1:0] r_val_c, r_val_a, r_val_b;
    assign w_src_a = (bus.D_icode inside {ICODE_RRMOVQ, ICODE_RMMOVQ, ICODE_OPQ, ICODE_PUSHQ}) ? bus.D_rA :
                     (bus.D_icode inside {ICODE_RET, ICODE_POPQ}) ? REG_RSP : REG_NONE;
    assign w_src_b = (bus.D_icode inside {ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_OPQ}) ? bus.D_rB :
                     (bus.D_icode inside {ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ}) ? REG_RSP : REG_NONE;
    assign w_dst_e = (bus.D_icode inside {ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_OPQ}) ? bus.D_rB :
                     (bus.D_icode inside {ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ}) ? REG_RSP : REG_NONE;
    assign w_dst_m = (bus.D_icode inside {ICODE_MRMOVQ, ICODE_POPQ}) ? bus.D_rA : REG_NONE;
    y86_regfile #(.DATA_W(DATA_W), .RSP_INIT(RSP_INIT)) u_rf (
        .clk(clk), .rst(rst),
        .i_src_a(w_src_a), .i_src_b(w_src_b),
        .i_dst_e(bus.W_dstE), .i_dst_m(bus.W_dstM),
        .i_val_e(bus.W_valE), .i_val_m(bus.W_valM),
        .o_val_a(w_rf_a), .o_val_b(w_rf_b)
    );
`ifdef DECODE_FWD_EN
    assign w_fwd_a = (w_src_a == REG_NONE) ? '0 : (w_src_a == bus.e_dstE) ? bus.e_valE :
                     (w_src_a == bus.M_dstM) ? bus.m_valM : (w_src_a == bus.M_dstE) ? bus.M_valE :
                     (w_src_a == bus.W_dstM) ? bus.W_valM : (w_src_a == bus.W_dstE) ? bus.W_valE : w_rf_a;
    assign w_fwd_b = (w_src_b == REG_NONE) ? '0 : (w_src_b == bus.e_dstE) ? bus.e_valE :
                     (w_src_b == bus.M_dstM) ? bus.m_valM : (w_src_b == bus.M_dstE) ? bus.M_valE :
                     (w_src_b == bus.W_dstM) ? bus.W_valM : (w_src_b == bus.W_dstE) ? bus.W_valE : w_rf_b;
`else
    // The RF read returns the pre-edge value, so the W bypass keeps a same-cycle read coherent.
    assign w_fwd_a = (w_src_a == REG_NONE) ? '0 : (w_src_a == bus.W_dstM) ? bus.W_valM :
                     (w_src_a == bus.W_dstE) ? bus.W_valE : w_rf_a;
    assign w_fwd_b = (w_src_b == REG_NONE) ? '0 : (w_src_b == bus.W_dstM) ? bus.W_valM :
                     (w_src_b == bus.W_dstE) ? bus.W_valE : w_rf_b;
    logic w_unused;
    assign w_unused = ^{bus.e_dstE, bus.e_valE, bus.M_dstE, bus.M_valE, bus.M_dstM, bus.m_valM};
`endif
    assign w_val_a = (bus.D_icode inside {ICODE_JXX, ICODE_CALL}) ? bus.D_valP : w_fwd_a;
    assign w_val_b = w_fwd_b;
    always_ff @(posedge clk) begin
        if (rst || bus.E_bubble) begin
            r_stat  <= BUBBLE_STAT;
            r_icode <= BUBBLE_ICODE;
            r_ifun  <= BUBBLE_IFUN;
            r_val_c <= '0;
            r_val_a <= '0;
            r_val_b <= '0;
            r_dst_e <= REG_NONE;
            r_dst_m <= REG_NONE;
            r_src_a <= REG_NONE;
            r_src_b <= REG_NONE;
        end else begin
            r_stat  <= bus.D_stat;
            r_icode <= bus.D_icode;
            r_ifun  <= bus.D_ifun;
            r_val_c <= bus.D_valC;
            r_val_a <= w_val_a;
            r_val_b <= w_val_b;
            r_dst_e <= w_dst_e;
            r_dst_m <= w_dst_m;
            r_src_a <= w_src_a;
            r_src_b <= w_src_b;
        end
    end
    assign bus.d_srcA  = w_src_a;
    assign bus.d_srcB  = w_src_b;
    assign bus.E_stat  = r_stat;
    assign bus.E_icode = r_icode;
    assign bus.E_ifun  = r_ifun;
    assign bus.E_valC  = r_val_c;
    assign bus.E_valA  = r_val_a;
    assign bus.E_valB  = r_val_b;
    assign bus.E_dstE  = r_dst_e;
    assign bus.E_dstM  = r_dst_m;
    assign bus.E_srcA  = r_src_a;
    assign bus.E_srcB  = r_src_b;
endmodule
